// File: rtl/jam_cost_loader.sv
// Cost-matrix front end for the JAM: streams in an 8x8 matrix and holds JAM in reset until it is complete.
// It serves registered (W, J) lookups while JAM runs, and keeps JAM's result until the consumer accepts it.
module jam_cost_loader #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_last,
    output logic              load_err,
    output logic              jam_rst,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              jam_valid,
    input  logic [9:0]        jam_min_cost,
    input  logic [3:0]        jam_match_count,
    output logic              res_valid,
    output logic [9:0]        res_min_cost,
    output logic [3:0]        res_match_count,
    input  logic              res_ack
);

    localparam int ADDR_W = 2 * IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [COST_W-1:0]   mem [DEPTH];
    logic                xfer;
    logic                at_end;
    logic                frame_ok;
    logic                frame_err;

    // in_last must coincide exactly with the final matrix slot; anything else restarts the load.
    assign xfer      = in_valid && in_ready && (state == LOAD);
    assign at_end    = (wr_ptr == '1);
    assign frame_ok  = xfer && at_end && in_last;
    assign frame_err = xfer && (at_end != in_last);

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (frame_ok)  next_state = RUN;
            RUN:     if (jam_valid) next_state = DONE;
            DONE:    if (res_ack)   next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Storage carries no reset so it can map onto RAM; every matrix is fully rewritten before RUN.
    always_ff @(posedge CLK) begin
        if (xfer)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= LOAD;
            wr_ptr          <= '0;
            in_ready        <= 1'b0;
            load_err        <= 1'b0;
            jam_rst         <= 1'b1;
            Cost            <= '0;
            res_valid       <= 1'b0;
            res_min_cost    <= '0;
            res_match_count <= '0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == LOAD);
            jam_rst  <= (next_state != RUN);
            load_err <= frame_err;

            if (xfer)
                wr_ptr <= (frame_ok || frame_err) ? '0 : wr_ptr + 1'b1;

            // One-cycle lookup lines up with JAM's registered W/J -> Cost -> accumulate path.
            if (state == RUN)
                Cost <= mem[{W, J}];

            if (state == RUN && jam_valid) begin
                res_valid       <= 1'b1;
                res_min_cost    <= jam_min_cost;
                res_match_count <= jam_match_count;
            end else if (state == DONE && res_ack) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jam_cost_loader.sv
// Directed bench for jam_cost_loader: loads, framing errors, backpressure, lookups, result handshake and reset.
module tb_jam_cost_loader;

    logic       CLK;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_last;
    logic       load_err;
    logic       jam_rst;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       jam_valid;
    logic [9:0] jam_min_cost;
    logic [3:0] jam_match_count;
    logic       res_valid;
    logic [9:0] res_min_cost;
    logic [3:0] res_match_count;
    logic       res_ack;

    int checks;
    int errors;
    int err_seen;

    jam_cost_loader #(.COST_W(7), .IDX_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .load_err(load_err), .jam_rst(jam_rst),
        .W(W), .J(J), .Cost(Cost),
        .jam_valid(jam_valid), .jam_min_cost(jam_min_cost), .jam_match_count(jam_match_count),
        .res_valid(res_valid), .res_min_cost(res_min_cost), .res_match_count(res_match_count),
        .res_ack(res_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] cost_of(input int mode, input int n);
        case (mode)
            0:       return 7'(n);
            1:       return 7'((n * 37 + 11) % 128);
            default: return 7'((n * 5 + 3) % 128);
        endcase
    endfunction

    // Offers words start..start+count-1; returns at the negedge after the final transfer.
    task automatic load_words(input int start, input int count, input int last_idx,
                              input int mode, input bit gaps, input bit jv_last);
        int  waitc;
        bit  accepted;
        err_seen = 0;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge CLK);
                    if (load_err) err_seen++;
                    in_valid = 1'b0;
                    @(posedge CLK);
                end
            end
            waitc = 0;
            forever begin
                @(negedge CLK);
                if (load_err) err_seen++;
                in_valid  = 1'b1;
                in_data   = cost_of(mode, start + i);
                in_last   = (start + i == last_idx);
                jam_valid = jv_last && (i == count - 1);
                accepted  = in_ready;
                @(posedge CLK);
                if (accepted) break;
                waitc++;
                if (waitc > 100) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL load_timeout word %0d in_ready=%0b required 1", start + i, in_ready);
                    break;
                end
            end
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        jam_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0 || load_err !== 1'b0 || jam_rst !== 1'b1 || Cost !== 7'd0 ||
            res_valid !== 1'b0 || res_min_cost !== 10'd0 || res_match_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got rdy=%0b err=%0b jrst=%0b cost=%0d rv=%0b rmc=%0d rcnt=%0d required 0 0 1 0 0 0 0",
                     in_ready, load_err, jam_rst, Cost, res_valid, res_min_cost, res_match_count);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset got %0b required 1", in_ready);
        end
    endtask

    task automatic test_ramp_load();
        int lw[3] = '{3, 7, 0};
        int lj[3] = '{5, 7, 0};
        load_words(0, 63, 63, 0, 1'b0, 1'b0);
        checks++;
        if (jam_rst !== 1'b1 || in_ready !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_before_last got jrst=%0b rdy=%0b err=%0b required 1 1 0", jam_rst, in_ready, load_err);
        end
        load_words(63, 1, 63, 0, 1'b0, 1'b0);
        checks++;
        if (jam_rst !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_enter_run got jrst=%0b rdy=%0b required 0 0", jam_rst, in_ready);
        end
        // Words offered during RUN must be refused; res_ack must not disturb RUN.
        in_valid = 1'b1;
        in_data  = 7'd99;
        res_ack  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b0 || jam_rst !== 1'b0) begin
                errors++;
                $display("[TB] FAIL run_ignores_input cycle %0d got rdy=%0b jrst=%0b required 0 0", c, in_ready, jam_rst);
            end
        end
        in_valid = 1'b0;
        res_ack  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            W = 3'(lw[k]);
            J = 3'(lj[k]);
            @(negedge CLK);
            checks++;
            if (Cost !== 7'(8 * lw[k] + lj[k])) begin
                errors++;
                $display("[TB] FAIL ramp_lookup w=%0d j=%0d got %0d required %0d", lw[k], lj[k], Cost, 8 * lw[k] + lj[k]);
            end
        end
    endtask

    task automatic test_result_handshake();
        jam_valid       = 1'b1;
        jam_min_cost    = 10'd0;
        jam_match_count = 4'd1;
        @(negedge CLK);
        checks++;
        if (res_valid !== 1'b1 || res_min_cost !== 10'd0 || res_match_count !== 4'd1 || jam_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_capture got rv=%0b mc=%0d cnt=%0d jrst=%0b required 1 0 1 1",
                     res_valid, res_min_cost, res_match_count, jam_rst);
        end
        jam_min_cost    = 10'd999;
        jam_match_count = 4'd15;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            checks++;
            if (res_valid !== 1'b1 || res_min_cost !== 10'd0 || res_match_count !== 4'd1 ||
                jam_rst !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL result_hold cycle %0d got rv=%0b mc=%0d cnt=%0d jrst=%0b rdy=%0b required 1 0 1 1 0",
                         c, res_valid, res_min_cost, res_match_count, jam_rst, in_ready);
            end
        end
        jam_valid = 1'b0;
        res_ack   = 1'b1;
        @(negedge CLK);
        res_ack = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || jam_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_ack got rv=%0b rdy=%0b jrst=%0b required 0 1 1", res_valid, in_ready, jam_rst);
        end
        res_ack = 1'b1;
        @(negedge CLK);
        res_ack = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_in_load got rdy=%0b rv=%0b required 1 0", in_ready, res_valid);
        end
    endtask

    task automatic test_framing();
        load_words(0, 11, 10, 0, 1'b0, 1'b0);
        checks++;
        if (load_err !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL early_last_err got err=%0b rdy=%0b required 1 1", load_err, in_ready);
        end
        @(negedge CLK);
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_pulse_width got %0b required 0", load_err);
        end
        load_words(0, 64, -1, 0, 1'b0, 1'b0);
        checks++;
        if (err_seen !== 0 || load_err !== 1'b1 || jam_rst !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL missing_last got early=%0d err=%0b jrst=%0b rdy=%0b required 0 1 1 1",
                     err_seen, load_err, jam_rst, in_ready);
        end
        jam_valid       = 1'b1;
        jam_min_cost    = 10'd77;
        jam_match_count = 4'd3;
        @(negedge CLK);
        jam_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jam_valid_in_load got rv=%0b rdy=%0b required 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        // jam_valid rides along with the final word and must be ignored.
        load_words(0, 64, 63, 1, 1'b1, 1'b1);
        checks++;
        if (jam_rst !== 1'b0 || res_valid !== 1'b0 || err_seen !== 0) begin
            errors++;
            $display("[TB] FAIL gapped_load_run got jrst=%0b rv=%0b errs=%0d required 0 0 0", jam_rst, res_valid, err_seen);
        end
        for (int n = 0; n < 64; n++) begin
            W = 3'(n / 8);
            J = 3'(n % 8);
            @(negedge CLK);
            checks++;
            if (Cost !== cost_of(1, n)) begin
                errors++;
                $display("[TB] FAIL sweep_lookup n=%0d got %0d required %0d", n, Cost, cost_of(1, n));
            end
        end
        jam_valid       = 1'b1;
        jam_min_cost    = 10'd40;
        jam_match_count = 4'd8;
        @(negedge CLK);
        jam_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_min_cost !== 10'd40 || res_match_count !== 4'd8) begin
            errors++;
            $display("[TB] FAIL second_result got rv=%0b mc=%0d cnt=%0d required 1 40 8", res_valid, res_min_cost, res_match_count);
        end
        res_ack = 1'b1;
        @(negedge CLK);
        res_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        int lw[3] = '{0, 7, 3};
        int lj[3] = '{0, 7, 5};
        load_words(0, 30, -1, 1, 1'b0, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b0 || jam_rst !== 1'b1 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_load got rdy=%0b jrst=%0b err=%0b required 0 1 0", in_ready, jam_rst, load_err);
        end
        RST = 1'b0;
        @(negedge CLK);
        load_words(0, 63, -1, 2, 1'b0, 1'b0);
        checks++;
        if (err_seen !== 0 || load_err !== 1'b0 || jam_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fresh_load_63 got errs=%0d err=%0b jrst=%0b required 0 0 1", err_seen, load_err, jam_rst);
        end
        load_words(63, 1, 63, 2, 1'b0, 1'b0);
        checks++;
        if (jam_rst !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fresh_load_run got jrst=%0b err=%0b required 0 0", jam_rst, load_err);
        end
        for (int k = 0; k < 3; k++) begin
            W = 3'(lw[k]);
            J = 3'(lj[k]);
            @(negedge CLK);
            checks++;
            if (Cost !== cost_of(2, 8 * lw[k] + lj[k])) begin
                errors++;
                $display("[TB] FAIL fresh_lookup w=%0d j=%0d got %0d required %0d",
                         lw[k], lj[k], Cost, cost_of(2, 8 * lw[k] + lj[k]));
            end
        end
        jam_valid       = 1'b1;
        jam_min_cost    = 10'd123;
        jam_match_count = 4'd7;
        @(negedge CLK);
        jam_valid = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        checks++;
        if (res_valid !== 1'b0 || res_min_cost !== 10'd0 || res_match_count !== 4'd0 ||
            jam_rst !== 1'b1 || Cost !== 7'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_done got rv=%0b mc=%0d cnt=%0d jrst=%0b cost=%0d rdy=%0b required 0 0 0 1 0 0",
                     res_valid, res_min_cost, res_match_count, jam_rst, Cost, in_ready);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_done_reset got %0b required 1", in_ready);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        err_seen        = 0;
        RST             = 1'b1;
        in_valid        = 1'b0;
        in_data         = '0;
        in_last         = 1'b0;
        W               = '0;
        J               = '0;
        jam_valid       = 1'b0;
        jam_min_cost    = '0;
        jam_match_count = '0;
        res_ack         = 1'b0;
        test_reset();
        test_ramp_load();
        test_result_handshake();
        test_framing();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
